wheel_slew_limiter: RTL

//  Rate limiter between bangbang_controller and pwm_converter. One instance per wheel.

---
 rtl/wheel_pkg.sv | 41 ++++
 rtl/slew_prescaler.sv | 28 ++
 rtl/wheel_slew_limiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/wheel_pkg.sv
// Shared wheel-command definitions: command width, FSM encoding and the saturating step helper.
package wheel_pkg;

  localparam int unsigned WHEEL_CMD_W     = 8;
  localparam int unsigned CALC_W          = WHEEL_CMD_W + 1;
  localparam int unsigned CMD_MAX_DEFAULT = 63;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RAMP    = 2'd1;
  localparam logic [1:0] ST_REVERSE = 2'd2;
  localparam logic [1:0] ST_DWELL   = 2'd3;

  typedef logic signed [CALC_W-1:0] calc_t;

  function automatic calc_t clamp_cmd(input calc_t val, input calc_t lim);
    calc_t res;
    if (val > lim) begin
      res = lim;
    end else if (val < -lim) begin
      res = -lim;
    end else begin
      res = val;
    end
    return res;
  endfunction

  // Moves cur toward dst by at most step, landing exactly on dst rather than overshooting.
  function automatic calc_t sat_step(input calc_t cur, input calc_t dst, input calc_t step,
                                     input calc_t lim);
    calc_t nxt;
    if (cur < dst) begin
      nxt = ((dst - cur) > step) ? (cur + step) : dst;
    end else if (cur > dst) begin
      nxt = ((cur - dst) > step) ? (cur - step) : dst;
    end else begin
      nxt = cur;
    end
    return clamp_cmd(nxt, lim);
  endfunction

endpackage

// File: rtl/slew_prescaler.sv
// Divides tick_enable pulses by RATE_DIV into a single-cycle update strobe.
module slew_prescaler #(
  parameter int unsigned RATE_DIV = 1000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick_enable,
  output logic o_update
);

  localparam int unsigned CNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last   = (r_cnt == CNT_LAST);
  assign o_update = i_tick_enable && w_last;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_tick_enable) begin
      r_cnt <= w_last ? '0 : (r_cnt + 1'b1);
    end
  end

endmodule

// File: rtl/wheel_slew_limiter.sv
// Per-wheel command slew limiter with zero-crossing dwell on sign reversal.
// Build option: SLEW_FAST_DECEL_EN makes every |cmd| reducing step use DECEL_STEP.
module wheel_slew_limiter
  import wheel_pkg::*;
#(
  parameter int unsigned STEP          = 4,
  parameter int unsigned RATE_DIV      = 1000,
  parameter int unsigned CMD_MAX       = CMD_MAX_DEFAULT,
  parameter int unsigned DWELL_UPDATES = 2,
  parameter int unsigned DECEL_STEP    = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic                          i_tick_enable,
  input  logic signed [WHEEL_CMD_W-1:0] i_cmd_in,
  output logic signed [WHEEL_CMD_W-1:0] o_cmd_out,
  output logic                          o_at_target
);

  localparam int unsigned DWELL_W = (DWELL_UPDATES > 1) ? $clog2(DWELL_UPDATES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_UPDATES - 1);
  localparam calc_t ZERO      = '0;
  localparam calc_t CMD_MAX_S = calc_t'(CMD_MAX);
  localparam calc_t STEP_S    = calc_t'(STEP);

  if (STEP == 0 || STEP > CMD_MAX) begin : g_bad_step
    $error("wheel_slew_limiter: STEP must lie in 1..CMD_MAX");
  end
  if (RATE_DIV == 0) begin : g_bad_rate
    $error("wheel_slew_limiter: RATE_DIV must be at least 1");
  end
  if (CMD_MAX == 0 || CMD_MAX > 127) begin : g_bad_max
    $error("wheel_slew_limiter: CMD_MAX must lie in 1..127");
  end
  if (DWELL_UPDATES == 0) begin : g_bad_dwell
    $error("wheel_slew_limiter: DWELL_UPDATES must be at least 1");
  end
  if (DECEL_STEP == 0 || DECEL_STEP > CMD_MAX) begin : g_bad_decel
    $error("wheel_slew_limiter: DECEL_STEP must lie in 1..CMD_MAX");
  end

  logic               w_update;
  calc_t              w_cmd_in;
  calc_t              w_tgt;
  calc_t              w_cur;
  calc_t              w_ramp_step;
  calc_t              w_rev_step;
  calc_t              w_ramp_next;
  calc_t              w_rev_next;
  logic               w_opposite;
  logic [1:0]         w_state_d;
  calc_t              w_cmd_d;
  logic [DWELL_W-1:0] w_dwell_d;
  logic               w_at_d;

  logic [1:0]                   r_state;
  logic signed [WHEEL_CMD_W-1:0] r_cmd;
  logic [DWELL_W-1:0]           r_dwell_cnt;
  logic                         r_at_target;

  slew_prescaler #(
    .RATE_DIV(RATE_DIV)
  ) u_prescaler (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_tick_enable(i_tick_enable),
    .o_update     (w_update)
  );

  assign w_cmd_in = calc_t'(i_cmd_in);
  assign w_tgt    = i_enable ? clamp_cmd(w_cmd_in, CMD_MAX_S) : ZERO;
  assign w_cur    = calc_t'(r_cmd);

  assign w_opposite = (w_cur != ZERO) && (w_tgt != ZERO) &&
                      (w_cur[CALC_W-1] != w_tgt[CALC_W-1]);

`ifdef SLEW_FAST_DECEL_EN
  localparam calc_t DECEL_S = calc_t'(DECEL_STEP);
  logic w_shrinking;

  assign w_shrinking = ((w_cur > ZERO) && (w_tgt < w_cur)) ||
                       ((w_cur < ZERO) && (w_tgt > w_cur));
  assign w_ramp_step = w_shrinking ? DECEL_S : STEP_S;
  assign w_rev_step  = DECEL_S;
`else
  assign w_ramp_step = STEP_S;
  assign w_rev_step  = STEP_S;
`endif

  assign w_ramp_next = sat_step(w_cur, w_tgt, w_ramp_step, CMD_MAX_S);
  assign w_rev_next  = sat_step(w_cur, ZERO, w_rev_step, CMD_MAX_S);

  // HOLD, RAMP and REVERSE share one rule set: an opposite-sign target drives toward zero,
  // anything else ramps toward the target; a step that lands on the target is HOLD.
  always_comb begin
    w_state_d = r_state;
    w_cmd_d   = w_cur;
    w_dwell_d = r_dwell_cnt;
    w_at_d    = r_at_target;
    if (w_update) begin
      case (r_state)
        ST_HOLD, ST_RAMP, ST_REVERSE: begin
          if (w_opposite) begin
            w_cmd_d = w_rev_next;
            if (w_rev_next == ZERO) begin
              w_state_d = ST_DWELL;
              w_dwell_d = '0;
            end else begin
              w_state_d = ST_REVERSE;
            end
          end else begin
            w_cmd_d   = w_ramp_next;
            w_state_d = (w_ramp_next == w_tgt) ? ST_HOLD : ST_RAMP;
          end
        end
        ST_DWELL: begin
          w_cmd_d = ZERO;
          if (r_dwell_cnt == DWELL_LAST) begin
            w_state_d = ST_RAMP;
          end else begin
            w_dwell_d = r_dwell_cnt + 1'b1;
          end
        end
        default: begin
          w_state_d = ST_HOLD;
          w_cmd_d   = ZERO;
          w_dwell_d = '0;
        end
      endcase
      w_at_d = (w_state_d == ST_HOLD) && (w_cmd_d == w_tgt);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_HOLD;
      r_cmd       <= '0;
      r_dwell_cnt <= '0;
      r_at_target <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_cmd       <= w_cmd_d[WHEEL_CMD_W-1:0];
      r_dwell_cnt <= w_dwell_d;
      r_at_target <= w_at_d;
    end
  end

  assign o_cmd_out   = r_cmd;
  assign o_at_target = r_at_target;

endmodule
